// File: rtl/game_pkg.sv
// Shared types for the game status tracker: state encoding, BCD digit type
// and score helpers.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    LOSE = 3'd3,
    WIN  = 3'd4
  } game_state_t;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Decimal value of a two-digit BCD score, out-of-range digits clamped to 9.
  function automatic logic [6:0] bcd_value(input bcd_t tens, input bcd_t units);
    return 7'(bcd_sat(tens)) * 7'd10 + 7'(bcd_sat(units));
  endfunction

endpackage

// File: rtl/game_status_tracker_if.sv
// Collision/score inputs from the game controller and the game-level status
// returned to the drawers.
interface game_status_tracker_if;
  import game_pkg::*;

  logic        startOfFrame;
  logic        collision_lostLife;
  logic        mineHitPulse;
  bcd_t        score_top;
  bcd_t        score_bottom;
  logic        start_key;
  game_state_t game_state;
  logic [2:0]  lives;
  logic        invulnerable;
  logic        smiley_visible;
  logic        freeze;
  logic        lifeLostPulse;
  bcd_t        time_top;
  bcd_t        time_bottom;

  modport master (
    output startOfFrame, collision_lostLife, mineHitPulse, score_top, score_bottom, start_key,
    input  game_state, lives, invulnerable, smiley_visible, freeze, lifeLostPulse,
           time_top, time_bottom
  );

  modport slave (
    input  startOfFrame, collision_lostLife, mineHitPulse, score_top, score_bottom, start_key,
    output game_state, lives, invulnerable, smiley_visible, freeze, lifeLostPulse,
           time_top, time_bottom
  );
endinterface

// File: rtl/game_status_tracker_frame_countdown.sv
// Frame counter and BCD seconds down-counter; seconds saturate at 00.
module frame_countdown
  import game_pkg::*;
#(
  parameter int GAME_SECONDS   = 99,
  parameter int FRAMES_PER_SEC = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  input  logic startOfFrame,
  output bcd_t time_top,
  output bcd_t time_bottom,
  output logic zero
);

  localparam int            FW         = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam bcd_t          SEC_TOP    = 4'(GAME_SECONDS / 10);
  localparam bcd_t          SEC_BOT    = 4'(GAME_SECONDS % 10);

  logic [FW-1:0] frame_q, frame_d;
  bcd_t          top_q, top_d, bot_q, bot_d;

  always_comb begin
    frame_d = frame_q;
    top_d   = top_q;
    bot_d   = bot_q;
    if (load) begin
      frame_d = '0;
      top_d   = SEC_TOP;
      bot_d   = SEC_BOT;
    end else if (run && startOfFrame) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        if (bot_q != 4'd0) begin
          bot_d = bot_q - 4'd1;
        end else if (top_q != 4'd0) begin
          top_d = top_q - 4'd1;
          bot_d = 4'd9;
        end
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      frame_q <= frame_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
    end
  end

  assign time_top    = top_q;
  assign time_bottom = bot_q;
  assign zero        = (top_q == 4'd0) && (bot_q == 4'd0);

endmodule

// File: rtl/game_status_tracker.sv
// Game-level state from collisions and score: lives, post-hit invulnerability
// with blink, countdown clock and win/lose.
module game_status_tracker
  import game_pkg::*;
#(
  parameter int INIT_LIVES     = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int BLINK_FRAMES   = 4,
  parameter int WIN_SCORE      = 50,
  parameter int GAME_SECONDS   = 99,
  parameter int FRAMES_PER_SEC = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  game_status_tracker_if.slave  bus
);

  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

  game_state_t state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  invuln_q, invuln_d;
  logic [7:0]  blink_q, blink_d;
  logic        vis_q, vis_d;
  logic        pulse_q, pulse_d;
  logic        hit_q, hit_d;
  logic        key_q, inv_q, freeze_q;
  logic        start_edge, in_round, hit_now, won, time_zero, load;

  assign start_edge = bus.start_key & ~key_q;
  assign in_round   = (state_q == PLAY) || (state_q == HIT);
  assign hit_now    = hit_q | bus.collision_lostLife | bus.mineHitPulse;
  assign won        = bcd_value(bus.score_top, bus.score_bottom) >= 7'(WIN_SCORE);
  assign load       = (state_q == IDLE) && start_edge;

  frame_countdown #(
    .GAME_SECONDS  (GAME_SECONDS),
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_countdown (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .run         (in_round),
    .startOfFrame(bus.startOfFrame),
    .time_top    (bus.time_top),
    .time_bottom (bus.time_bottom),
    .zero        (time_zero)
  );

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    invuln_d = invuln_q;
    blink_d  = blink_q;
    vis_d    = vis_q;
    pulse_d  = 1'b0;
    hit_d    = hit_q | (in_round & (bus.collision_lostLife | bus.mineHitPulse));
    if (bus.startOfFrame) hit_d = 1'b0;

    case (state_q)
      IDLE: if (start_edge) begin
        state_d = PLAY;
        lives_d = 3'(INIT_LIVES);
      end
      LOSE, WIN: if (start_edge) state_d = IDLE;
      PLAY, HIT: if (bus.startOfFrame) begin
        if (state_q == PLAY && hit_now) begin
          lives_d = lives_q - 3'd1;
          pulse_d = 1'b1;
          if (lives_q == 3'd1) begin
            state_d = LOSE;
          end else begin
            state_d  = HIT;
            invuln_d = INVULN_LOAD;
            blink_d  = '0;
          end
        end else if (won) begin
          state_d = WIN;
        end else if (time_zero) begin
          state_d = LOSE;
        end else if (state_q == HIT) begin
          if (invuln_q == 8'd1) begin
            state_d = PLAY;
          end else begin
            invuln_d = invuln_q - 8'd1;
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q + 8'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Blink phase always starts hidden on HIT entry; solid outside HIT.
    if (state_d != HIT)      vis_d = 1'b1;
    else if (state_q != HIT) vis_d = 1'b0;
  end

  // key_q resets high so a key held across reset must be released first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lives_q  <= '0;
      invuln_q <= '0;
      blink_q  <= '0;
      vis_q    <= 1'b1;
      pulse_q  <= 1'b0;
      hit_q    <= 1'b0;
      key_q    <= 1'b1;
      inv_q    <= 1'b0;
      freeze_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      invuln_q <= invuln_d;
      blink_q  <= blink_d;
      vis_q    <= vis_d;
      pulse_q  <= pulse_d;
      hit_q    <= hit_d;
      key_q    <= bus.start_key;
      inv_q    <= (state_d == HIT);
      freeze_q <= (state_d == IDLE) || (state_d == LOSE) || (state_d == WIN);
    end
  end

  assign bus.game_state     = state_q;
  assign bus.lives          = lives_q;
  assign bus.invulnerable   = inv_q;
  assign bus.smiley_visible = vis_q;
  assign bus.freeze         = freeze_q;
  assign bus.lifeLostPulse  = pulse_q;

endmodule

// File: tb/tb_game_status_tracker.sv
// Directed bench for game_status_tracker with a frame-level behavioural model.
module tb_game_status_tracker;
  import game_pkg::*;

  localparam int INIT_LIVES     = 3;
  localparam int INVULN_FRAMES  = 60;
  localparam int BLINK_FRAMES   = 4;
  localparam int WIN_SCORE      = 50;
  localparam int GAME_SECONDS   = 99;
  localparam int FRAMES_PER_SEC = 30;

  logic clk;
  logic reset;
  game_status_tracker_if bus();

  game_status_tracker dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int n_pulse = 0;
  int cyc_n   = 0;

  // Model state: whole seconds, frames into the current second, frames since HIT entry.
  game_state_t m_state;
  int          m_lives, m_sec, m_fc, m_age;
  bit          m_latched, m_key, m_pulse;

  function automatic int dig(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_lives = 0; m_sec = 0; m_fc = 0; m_age = 0;
    m_latched = 0; m_key = 1; m_pulse = 0;
  endtask

  // Advance the model by the clock edge that will sample the current inputs.
  task automatic model_step();
    bit st_edge, hit_in, round, hit, zero;
    int score;
    st_edge = bus.start_key && !m_key;
    m_key   = bus.start_key;
    hit_in  = bus.collision_lostLife || bus.mineHitPulse;
    round   = (m_state == PLAY) || (m_state == HIT);
    hit     = m_latched || hit_in;
    m_pulse = 0;
    if (m_state == IDLE) begin
      if (st_edge) begin
        m_state = PLAY; m_lives = INIT_LIVES; m_sec = GAME_SECONDS; m_fc = 0;
      end
    end else if (!round) begin
      if (st_edge) m_state = IDLE;
    end else if (bus.startOfFrame) begin
      score = dig(bus.score_top) * 10 + dig(bus.score_bottom);
      zero  = (m_sec == 0);
      m_fc++;
      if (m_fc == FRAMES_PER_SEC) begin
        m_fc = 0;
        if (m_sec > 0) m_sec--;
      end
      if (m_state == PLAY && hit) begin
        m_lives--;
        m_pulse = 1;
        if (m_lives == 0) m_state = LOSE;
        else begin m_state = HIT; m_age = 0; end
      end else if (score >= WIN_SCORE) m_state = WIN;
      else if (zero) m_state = LOSE;
      else if (m_state == HIT) begin
        m_age++;
        if (m_age == INVULN_FRAMES) m_state = PLAY;
      end
    end
    if (bus.startOfFrame) m_latched = 0;
    else if (round && hit_in) m_latched = 1;
  endtask

  task automatic compare_model();
    logic [17:0] act, exp;
    logic vis, frz;
    vis = (m_state == HIT) ? (((m_age / BLINK_FRAMES) % 2) == 1) : 1'b1;
    frz = (m_state == IDLE) || (m_state == LOSE) || (m_state == WIN);
    act = {bus.game_state, bus.lives, bus.invulnerable, bus.smiley_visible, bus.freeze,
           bus.lifeLostPulse, bus.time_top, bus.time_bottom};
    exp = {m_state, 3'(m_lives), (m_state == HIT), vis, frz, m_pulse,
           4'(m_sec / 10), 4'(m_sec % 10)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL model cycle %0d: dut=%h expected=%h (state,lives,inv,vis,frz,pulse,tt,tb)",
               cyc_n, act, exp);
    end
    if (bus.lifeLostPulse === 1'b1) n_pulse++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic sof, input logic coll, input logic mine);
    bus.startOfFrame       = sof;
    bus.collision_lostLife = coll;
    bus.mineHitPulse       = mine;
    if (reset) model_reset(); else model_step();
    @(negedge clk);
    cyc_n++;
    compare_model();
  endtask

  // len cycles, collisions on the first coll_n, optional mine on the startOfFrame cycle.
  task automatic frame(input int len, input int coll_n, input logic mine_sof);
    for (int i = 0; i < len - 1; i++) cyc(1'b0, i < coll_n, 1'b0);
    cyc(1'b1, 1'b0, mine_sof);
  endtask

  task automatic press();
    bus.start_key = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    bus.start_key = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  int p0;

  initial begin
    reset = 1'b1;
    bus.startOfFrame = 1'b0; bus.collision_lostLife = 1'b0; bus.mineHitPulse = 1'b0;
    bus.score_top = 4'd0; bus.score_bottom = 4'd0; bus.start_key = 1'b0;
    model_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("rst_state", bus.game_state, IDLE);
    check("rst_lives", bus.lives, 0);
    check("rst_vis", bus.smiley_visible, 1);
    check("rst_freeze", bus.freeze, 1);
    check("rst_time", {bus.time_top, bus.time_bottom}, 8'h00);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Start, then a frame with 200 colliding pixels
    press();
    check("start_state", bus.game_state, PLAY);
    check("start_lives", bus.lives, 3);
    check("start_time", {bus.time_top, bus.time_bottom}, 8'h99);
    check("start_freeze", bus.freeze, 0);
    p0 = n_pulse;
    frame(220, 200, 1'b0);
    frame(6, 0, 1'b0);
    frame(6, 0, 1'b0);
    check("hit_lives", bus.lives, 2);
    check("hit_state", bus.game_state, HIT);
    check("hit_inv", bus.invulnerable, 1);
    check("hit_pulses", n_pulse - p0, 1);

    // Hits every frame while invulnerable
    for (int i = 0; i < 58; i++) begin
      frame(6, 3, 1'b0);
      if (i == 0) check("blink_f3", bus.smiley_visible, 0);
      if (i == 1) check("blink_f4", bus.smiley_visible, 1);
      if (i == 5) check("blink_f8", bus.smiley_visible, 0);
    end
    check("inv_end_state", bus.game_state, PLAY);
    check("inv_end_lives", bus.lives, 2);

    // Two more spaced hits: mine on the frame edge, then a pixel collision
    frame(6, 0, 1'b1);
    check("mine_lives", bus.lives, 1);
    repeat (65) frame(6, 0, 1'b0);
    check("recover_state", bus.game_state, PLAY);
    frame(6, 1, 1'b0);
    check("lose_state", bus.game_state, LOSE);
    check("lose_lives", bus.lives, 0);
    check("lose_freeze", bus.freeze, 1);
    press();
    check("lose_to_idle", bus.game_state, IDLE);

    // Hit and win in the same frame
    press();
    frame(6, 1, 1'b0);
    repeat (61) frame(6, 0, 1'b0);
    check("pre_win_lives", bus.lives, 2);
    bus.score_top = 4'd5; bus.score_bottom = 4'd0;
    frame(6, 2, 1'b0);
    check("hitwin_lives", bus.lives, 1);
    check("hitwin_state", bus.game_state, HIT);
    frame(6, 0, 1'b0);
    check("win_state", bus.game_state, WIN);
    check("win_vis", bus.smiley_visible, 1);
    bus.score_top = 4'd0;
    press();
    check("win_to_idle", bus.game_state, IDLE);

    // Out-of-range tens digit clamps to 9 -> score 90 wins
    press();
    bus.score_top = 4'hA; bus.score_bottom = 4'd0;
    frame(6, 0, 1'b0);
    check("sat_win", bus.game_state, WIN);
    bus.score_top = 4'd0;
    press();

    // Full countdown with score 4/B (clamped to 49)
    press();
    bus.score_top = 4'd4; bus.score_bottom = 4'hB;
    repeat (FRAMES_PER_SEC) frame(4, 0, 1'b0);
    check("time_98", {bus.time_top, bus.time_bottom}, 8'h98);
    repeat (GAME_SECONDS * FRAMES_PER_SEC - FRAMES_PER_SEC) frame(4, 0, 1'b0);
    check("time_00", {bus.time_top, bus.time_bottom}, 8'h00);
    check("time_00_state", bus.game_state, PLAY);
    frame(4, 0, 1'b0);
    check("timeout_lose", bus.game_state, LOSE);
    bus.score_top = 4'd0; bus.score_bottom = 4'd0;
    press();

    // Asynchronous reset mid-HIT with the start key held
    press();
    frame(6, 1, 1'b0);
    check("pre_rst_state", bus.game_state, HIT);
    bus.start_key = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_state", bus.game_state, IDLE);
    check("async_rst_lives", bus.lives, 0);
    check("async_rst_inv", bus.invulnerable, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    check("held_key_idle", bus.game_state, IDLE);
    bus.start_key = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    press();
    check("restart_state", bus.game_state, PLAY);
    check("restart_lives", bus.lives, 3);
    check("restart_time", {bus.time_top, bus.time_bottom}, 8'h99);
    repeat (3) frame(6, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_status_tracker.md
# game_status_tracker

Receiving end of the game controller's collision interface. It consumes the per-pixel lost-life collision, the mine-hit pulse and the score digits, and turns them into game-level state: lives, post-hit invulnerability with a blink, a countdown clock, and win/lose. It sits between the game controller and the VGA object/HUD drawers; its outputs freeze movement and gate the smiley drawing.

## Interface
- INIT_LIVES, 3: lives loaded on game start (1..7).
- INVULN_FRAMES, 60: frames of invulnerability after a hit (1..255).
- BLINK_FRAMES, 4: smiley_visible toggles every BLINK_FRAMES frames while invulnerable.
- WIN_SCORE, 50: decimal score (0..99) that wins the game.
- GAME_SECONDS, 99: countdown start value (1..99).
- FRAMES_PER_SEC, 30: startOfFrame pulses per second.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- collision_lostLife  in  1  per-pixel smiley/explosion overlap, level.
- mineHitPulse  in  1  one-cycle mine hit; counts as a life hit.
- score_top, score_bottom  in  4 each  BCD score digits (tens, units).
- start_key  in  1  start/restart key, level, possibly held.
- game_state  out  3  current state encoding (package enum).
- lives  out  3  remaining lives.
- invulnerable  out  1  high while in HIT.
- smiley_visible  out  1  drawing enable for smiley.
- freeze  out  1  high in IDLE, LOSE, WIN.
- lifeLostPulse  out  1  one-cycle pulse per life lost.
- time_top, time_bottom  out  4 each  BCD remaining seconds.

## Operation
- States: IDLE, PLAY, HIT, LOSE, WIN.
- Start edge = start_key high and previous-cycle start_key low. A held key never retriggers.
- IDLE: start edge -> PLAY. Load lives=INIT_LIVES and time=GAME_SECONDS. Clear the frame counter.
- LOSE/WIN: start edge -> IDLE. lives and time hold until the next start.
- Hit latch: set by collision_lostLife or mineHitPulse on any cycle. It is cleared on every startOfFrame cycle after being sampled. One hit is counted per frame at most, however many pixels collide.
- Every state decision except the start edge is made only on startOfFrame cycles. Decisions apply at that clock edge, in priority order:
  1. PLAY with the hit latch set: decrement lives and pulse lifeLostPulse. If lives was 1, go to LOSE; otherwise go to HIT and load the invuln counter with INVULN_FRAMES.
  2. PLAY/HIT with 10*score_top+score_bottom >= WIN_SCORE: go to WIN.
  3. PLAY/HIT with time 0: go to LOSE.
  4. HIT: decrement the invuln counter. At 1 -> PLAY. Hits are ignored in HIT.
- Timer runs in PLAY and HIT only. The frame counter wraps 0..FRAMES_PER_SEC-1. At the wrap, seconds decrement in BCD and saturate at 00.
- smiley_visible: 1 outside HIT. In HIT it toggles every BLINK_FRAMES frames, starting at 0 on HIT entry.
- The hit latch captures nothing in IDLE, LOSE or WIN.
- Score digits > 9 are treated as 9.

## Timing
- All outputs are registered.
- Reset values: game_state=IDLE, lives=0, invulnerable=0, smiley_visible=1, freeze=1, lifeLostPulse=0, time_top=0, time_bottom=0.
- Reset is asynchronous and may occur mid-game; it forces IDLE immediately and clears the hit latch and all counters.
- Latency: a state change is visible the cycle after the sampled startOfFrame (or start edge). lifeLostPulse is high for exactly that one cycle.
- Collision on the startOfFrame cycle itself: it counts for the frame just ending, not the next one.
- Start edge coinciding with startOfFrame in IDLE: enter PLAY; frame evaluation begins with the next startOfFrame.
- A hit and a win in the same frame: the hit is applied. If lives reach 0, the result is LOSE; otherwise the win is evaluated at the next frame.

## Structure
- game_pkg: the game_state_t enum (IDLE=0, PLAY=1, HIT=2, LOSE=3, WIN=4) and a shared BCD digit typedef.
- Sub-module frame_countdown: owns the frame counter and the BCD seconds down-counter. Its interface is load, run, startOfFrame, time_top, time_bottom and zero.
- The FSM, hit latch, lives and invuln counter stay in the top.

## Test plan
- Reset, start edge, then 3 frames with collision_lostLife asserted on 200 pixels in frame 1 -> lives 3->2, one lifeLostPulse, state HIT, invulnerable=1.
- In HIT, hit every frame for 60 frames -> lives stay 2, smiley_visible toggles every 4 frames, then back to PLAY.
- Three hits separated by more than 60 frames -> lives reach 0, state LOSE, freeze=1; start edge -> IDLE.
- Score digits 5/0 with a hit in the same frame and lives=2 -> lives=1, state HIT; WIN on the next frame.
- Play with no events for 99*30 frames -> time counts 99..00, then LOSE; score 49 never wins.
- Assert reset mid-HIT while start_key is held -> IDLE immediately; releasing and pressing again restarts with lives=3, time=99.
